// File: rtl/sys_loader_pkg.sv
// Shared types and constants for the serial program loader.
// Frame layout: sync, base, count, words, optional checksum.
package sys_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_CNT,
    ST_DATA,
    ST_CHECK
  } ld_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] LD_SYNC = 8'hA5;
  localparam int LD_BYTES_PER_WORD = 4;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: synchronizer, mid-bit sampling, stop check.
// Emits one-cycle byte_vld or frm_err per received byte.
module uart_rx_byte
  import sys_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_vld,
  output logic [7:0] byte_data,
  output logic       frm_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  logic s1, s2, s3;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] sh;
  rx_state_t st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
      st <= RX_IDLE;
      cnt <= '0;
      bit_idx <= '0;
      sh <= '0;
      byte_vld <= 1'b0;
      byte_data <= '0;
      frm_err <= 1'b0;
    end else begin
      s1 <= rx;
      s2 <= s1;
      s3 <= s2;
      byte_vld <= 1'b0;
      frm_err <= 1'b0;
      unique case (st)
        RX_IDLE: begin
          if (s3 && !s2) begin
            st <= RX_START;
            cnt <= '0;
          end
        end
        RX_START: begin
          if (cnt == HALF) begin
            cnt <= '0;
            bit_idx <= '0;
            // a high line at mid-start means the edge was a glitch
            st <= s2 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (cnt == FULL) begin
            cnt <= '0;
            sh <= {s2, sh[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) st <= RX_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (cnt == FULL) begin
            cnt <= '0;
            st <= RX_IDLE;
            if (s2) begin
              byte_vld <= 1'b1;
              byte_data <= sh;
            end else begin
              frm_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: st <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sys_prog_loader.sv
// Frame FSM loading instruction words from a UART byte stream.
// Define LOADER_CHECKSUM_EN to require and verify a trailing CSUM byte.
module sys_prog_loader
  import sys_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W = 8
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset,
  input  logic              rx_i,
  output logic              ld_we,
  output logic [ADDR_W-1:0] ld_addr,
  output logic [31:0]       ld_wdata,
  output logic              ld_hold,
  output logic              ld_busy,
  output logic              ld_done,
  output logic              ld_err
);

  logic       byte_vld;
  logic [7:0] byte_data;
  logic       frm_err;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (SYS_clk),
    .rst      (SYS_reset),
    .rx       (rx_i),
    .byte_vld (byte_vld),
    .byte_data(byte_data),
    .frm_err  (frm_err)
  );

  ld_state_t         state;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        words_left;
  logic [1:0]        byte_idx;
  logic [23:0]       asm_q;

  assign ld_busy = (state != ST_IDLE);

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) csum <= '0;
    else if (byte_vld) csum <= (state == ST_IDLE) ? 8'h00 : (csum ^ byte_data);
  end
`else
  logic done_pend;
`endif

  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      state <= ST_IDLE;
      addr <= '0;
      words_left <= '0;
      byte_idx <= '0;
      asm_q <= '0;
      ld_we <= 1'b0;
      ld_addr <= '0;
      ld_wdata <= '0;
      ld_hold <= 1'b0;
      ld_done <= 1'b0;
      ld_err <= 1'b0;
`ifndef LOADER_CHECKSUM_EN
      done_pend <= 1'b0;
`endif
    end else begin
      ld_we <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      ld_done <= 1'b0;
`else
      ld_done <= done_pend;
      done_pend <= 1'b0;
`endif
      ld_hold <= (state != ST_IDLE);
      if (state != ST_IDLE && frm_err) begin
        state <= ST_IDLE;
        ld_err <= 1'b1;
      end else if (byte_vld) begin
        unique case (state)
          ST_IDLE: begin
            if (byte_data == LD_SYNC) begin
              ld_err <= 1'b0;
              ld_hold <= 1'b1;
              state <= ST_ADDR;
            end
          end
          ST_ADDR: begin
            addr <= ADDR_W'(byte_data);
            state <= ST_CNT;
          end
          ST_CNT: begin
            words_left <= byte_data;
            byte_idx <= '0;
            if (byte_data == 8'h00) begin
`ifdef LOADER_CHECKSUM_EN
              state <= ST_CHECK;
`else
              state <= ST_IDLE;
              ld_done <= 1'b1;
`endif
            end else begin
              state <= ST_DATA;
            end
          end
          ST_DATA: begin
            asm_q <= {asm_q[15:0], byte_data};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'(LD_BYTES_PER_WORD - 1)) begin
              ld_we <= 1'b1;
              ld_addr <= addr;
              ld_wdata <= {asm_q, byte_data};
              addr <= addr + ADDR_W'(1);
              words_left <= words_left - 8'd1;
              if (words_left == 8'd1) begin
`ifdef LOADER_CHECKSUM_EN
                state <= ST_CHECK;
`else
                state <= ST_IDLE;
                done_pend <= 1'b1;
`endif
              end
            end
          end
`ifdef LOADER_CHECKSUM_EN
          ST_CHECK: begin
            if (byte_data == csum) ld_done <= 1'b1;
            else ld_err <= 1'b1;
            state <= ST_IDLE;
          end
`endif
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sys_prog_loader.sv
// Directed bench for sys_prog_loader with a fast UART bit rate.
// Handles builds with or without LOADER_CHECKSUM_EN.
module tb_sys_prog_loader;

  localparam int CPB = 4;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx = 1'b1;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_wdata;
  logic          ld_hold;
  logic          ld_busy;
  logic          ld_done;
  logic          ld_err;

  always #5 clk = ~clk;

  sys_prog_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W(AW)
  ) dut (
    .SYS_clk  (clk),
    .SYS_reset(rst),
    .rx_i     (rx),
    .ld_we    (ld_we),
    .ld_addr  (ld_addr),
    .ld_wdata (ld_wdata),
    .ld_hold  (ld_hold),
    .ld_busy  (ld_busy),
    .ld_done  (ld_done),
    .ld_err   (ld_err)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [7:0]  we_addr [64];
  logic [31:0] we_data [64];
  int we_n = 0;
  int done_n = 0;
  int w0 = 0;
  int d0 = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (ld_we) begin
        if (we_n < 64) begin
          we_addr[we_n] <= ld_addr;
          we_data[we_n] <= ld_wdata;
        end
        we_n <= we_n + 1;
      end
      if (ld_done) done_n <= done_n + 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tx_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  logic [7:0] fq[$];

  task automatic tx_frame(input logic [7:0] cx, input int bad);
    logic [7:0] cs;
    bit ok;
    cs = cx;
    ok = 1'b1;
    tx_byte(8'hA5, 1'b1);
    foreach (fq[i]) begin
      if (ok) begin
        tx_byte(fq[i], i != bad);
        cs = cs ^ fq[i];
        if (i == bad) ok = 1'b0;
      end
    end
`ifdef LOADER_CHECKSUM_EN
    if (ok) tx_byte(cs, 1'b1);
`endif
    repeat (10) @(negedge clk);
  endtask

  task automatic mark();
    w0 = we_n;
    d0 = done_n;
  endtask

  task automatic check_end(input string tag, input int nwe, input int nd,
                           input logic err);
    chk({tag, "_nwe"}, 32'(we_n - w0), 32'(nwe));
    chk({tag, "_done"}, 32'(done_n - d0), 32'(nd));
    chk({tag, "_err"}, {31'd0, ld_err}, {31'd0, err});
    chk({tag, "_hold"}, {31'd0, ld_hold}, 32'd0);
    chk({tag, "_busy"}, {31'd0, ld_busy}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_we", {31'd0, ld_we}, 32'd0);
    chk("rst_addr", {24'd0, ld_addr}, 32'd0);
    chk("rst_wdata", ld_wdata, 32'd0);
    chk("rst_hold", {31'd0, ld_hold}, 32'd0);
    chk("rst_busy", {31'd0, ld_busy}, 32'd0);
    chk("rst_done", {31'd0, ld_done}, 32'd0);
    chk("rst_err", {31'd0, ld_err}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // two words at 0x10
    mark();
    fq = '{8'h10, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
           8'h01, 8'h23, 8'h45, 8'h67};
    tx_frame(8'h00, -1);
    check_end("t1", 2, 1, 1'b0);
    chk("t1_a0", {24'd0, we_addr[w0]}, 32'h10);
    chk("t1_d0", we_data[w0], 32'hDEADBEEF);
    chk("t1_a1", {24'd0, we_addr[w0+1]}, 32'h11);
    chk("t1_d1", we_data[w0+1], 32'h01234567);

`ifdef LOADER_CHECKSUM_EN
    mark();
    tx_frame(8'h01, -1);
    check_end("t2", 2, 0, 1'b1);
    chk("t2_d1", we_data[w0+1], 32'h01234567);
`endif

    // address wrap
    mark();
    fq = '{8'hFF, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
           8'h55, 8'h66, 8'h77, 8'h88};
    tx_frame(8'h00, -1);
    check_end("t3", 2, 1, 1'b0);
    chk("t3_a0", {24'd0, we_addr[w0]}, 32'hFF);
    chk("t3_d0", we_data[w0], 32'h11223344);
    chk("t3_a1", {24'd0, we_addr[w0+1]}, 32'h00);
    chk("t3_d1", we_data[w0+1], 32'h55667788);

    // stop bit low on second data byte
    mark();
    fq = '{8'h20, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    tx_frame(8'h00, 3);
    check_end("t4", 0, 0, 1'b1);
    mark();
    fq = '{8'h30, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    tx_frame(8'h00, -1);
    check_end("t4b", 1, 1, 1'b0);
    chk("t4b_a0", {24'd0, we_addr[w0]}, 32'h30);
    chk("t4b_d0", we_data[w0], 32'hCAFEBABE);

    // junk bytes, a short glitch, then an empty frame
    mark();
    tx_byte(8'h00, 1'b1);
    tx_byte(8'h7E, 1'b1);
    repeat (4) @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    fq = '{8'h00, 8'h00};
    tx_frame(8'h00, -1);
    check_end("t5", 0, 1, 1'b0);

    // reset in the middle of the second word
    mark();
    tx_byte(8'hA5, 1'b1);
    tx_byte(8'h40, 1'b1);
    tx_byte(8'h02, 1'b1);
    tx_byte(8'h11, 1'b1);
    tx_byte(8'h22, 1'b1);
    tx_byte(8'h33, 1'b1);
    tx_byte(8'h44, 1'b1);
    tx_byte(8'h55, 1'b1);
    repeat (4) @(negedge clk);
    chk("t6_nwe", 32'(we_n - w0), 32'd1);
    chk("t6_a0", {24'd0, we_addr[w0]}, 32'h40);
    chk("t6_d0", we_data[w0], 32'h11223344);
    chk("t6_hold", {31'd0, ld_hold}, 32'd1);
    chk("t6_busy", {31'd0, ld_busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rhold", {31'd0, ld_hold}, 32'd0);
    chk("t6_rbusy", {31'd0, ld_busy}, 32'd0);
    chk("t6_raddr", {24'd0, ld_addr}, 32'd0);
    chk("t6_rwdata", ld_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    mark();
    fq = '{8'h50, 8'h01, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
    tx_frame(8'h00, -1);
    check_end("t6b", 1, 1, 1'b0);
    chk("t6b_a0", {24'd0, we_addr[w0]}, 32'h50);
    chk("t6b_d0", we_data[w0], 32'hA1B2C3D4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sys_prog_loader.md
# sys_prog_loader

Serial program loader for the single-cycle MIPS system. It receives a framed byte stream on a UART line, assembles 32-bit instruction words, and drives a write port into instruction memory. While a frame is in progress it holds the CPU. It is the inbound counterpart of the system's LCD/HEX debug-output path: that path exports CPU state, this block imports program images without resynthesis.

## Interface
- CLKS_PER_BIT, 434: system clocks per UART bit (50 MHz / 115200); must be ≥ 4.
- ADDR_W, 8: instruction-memory word-address width.
- SYS_clk  input  1  system clock; all logic on rising edge.
- SYS_reset  input  1  asynchronous, active-high reset.
- rx_i  input  1  UART serial in: idle high, 8N1, LSB first.
- ld_we  output  1  one-cycle instruction-memory write strobe.
- ld_addr  output  ADDR_W  word address for ld_we.
- ld_wdata  output  32  instruction word for ld_we.
- ld_hold  output  1  high while a frame is active; gates the CPU's pc/register enable.
- ld_busy  output  1  high when the frame FSM is not IDLE.
- ld_done  output  1  one-cycle pulse when a frame completes successfully.
- ld_err  output  1  sticky error flag; cleared when the next sync byte is accepted.

## Operation
- Reset: all outputs 0. The FSM is in IDLE and the receiver is idle.
- rx_i passes through a 2-flop synchronizer before use.
- Byte receiver:
  - A falling edge while idle starts a byte. Sample at CLKS_PER_BIT/2; if the line is high, the start was a glitch and the receiver returns to idle.
  - After a valid start, sample 8 data bits, then the stop bit, each at CLKS_PER_BIT spacing.
  - Stop bit = 1: assert byte_vld for one cycle with the byte.
  - Stop bit = 0: assert frm_err for one cycle and discard the byte.
- Frame format: 0xA5 (sync), BASE, COUNT, then COUNT×4 data bytes (MSB first per word), then CSUM.
- FSM states: IDLE → ADDR → CNT → DATA → CHECK → IDLE.
  - IDLE: bytes other than 0xA5 are ignored. On 0xA5: ld_err←0, ld_hold←1, go to ADDR.
  - ADDR: latch BASE into the address counter (zero-extended or truncated to ADDR_W).
  - CNT: latch COUNT. COUNT=0 goes straight to CHECK; otherwise go to DATA.
  - DATA: shift each byte into a 32-bit assembly register. On the 4th byte, pulse ld_we with the completed word and the current address, then increment the address modulo 2^ADDR_W (wraps). After COUNT words, go to CHECK.
  - CHECK: CSUM must equal the XOR of BASE, COUNT and all data bytes. Match: pulse ld_done. Mismatch: ld_err←1. Either way return to IDLE.
- ld_hold drops in the cycle after the return to IDLE.
- frm_err in any non-IDLE state: abort to IDLE, ld_err←1, no further writes. Words already written stay written.
- A sync byte seen inside DATA is treated as data. There is no resynchronization mid-frame.

## Timing
- byte_vld fires at the mid-stop-bit sample, which is 9.5 bit-times after the start edge plus 2 synchronizer cycles.
- ld_we, ld_addr and ld_wdata are registered: valid together in the cycle after the 4th byte's byte_vld, for exactly one cycle.
- ld_done / ld_err update in the cycle after the CSUM byte_vld. ld_hold falls one cycle after that.
- Asynchronous reset mid-frame: immediately return to IDLE, all outputs 0, partial word discarded.
- Back-to-back bytes with no idle gap must be accepted.

## Configuration
- LOADER_CHECKSUM_EN defined: the frame carries CSUM and the CHECK state is active as described above.
- LOADER_CHECKSUM_EN undefined: there is no CSUM byte and no CHECK state. ld_done pulses in the cycle after the last word's ld_we; for COUNT=0 it pulses in the cycle after the COUNT byte. ld_err is set only by framing errors.

## Structure
- Package sys_loader_pkg holds the FSM state enum, LD_SYNC = 8'hA5, and the bytes-per-word constant (4).
- Sub-module uart_rx_byte contains the synchronizer, bit timer and shift register. Its outputs are byte_vld, byte_data[7:0] and frm_err. The top-level block contains the frame FSM, address counter, assembly register and checksum.

## Test plan
- CLKS_PER_BIT=4, checksum enabled. Send A5 10 02 DE AD BE EF 01 23 45 67 then CSUM = XOR of all bytes after sync. Expect ld_we at addr 0x10 with 0xDEADBEEF, then at 0x11 with 0x01234567, then one ld_done pulse; ld_hold low afterwards.
- Same frame with CSUM XOR 0x01 → both writes occur, ld_err=1, no ld_done; the next A5 clears ld_err.
- Send A5 FF 02 followed by two words → writes at 0xFF then 0x00 (address wrap).
- Force the stop bit low on the 2nd data byte → abort, ld_err=1, no ld_we, ld_hold low. A following valid frame completes normally.
- Send 00 7E, then a 1-sample low glitch, then A5 00 00 CSUM=00 → leading bytes ignored, glitch rejected, ld_done pulses with no writes.
- Assert SYS_reset during DATA → all outputs 0 immediately; a fresh frame after reset is loaded correctly.
